// File: rtl/multicycle_control.sv
`timescale 1ns/1ps
// Multi-cycle control sequencer for an RV32I datapath: one instruction spans 3-5 cycles,
// with ready-handshaked memories, sticky halt/illegal/bus-error flags and a retire counter.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               imem_read,
    output logic               ir_write,
    output logic               dmem_read,
    output logic               dmem_write,
    output logic               pc_write,
    output logic               pc_src,
    output logic               alu_src,
    output logic [2:0]         alu_op,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               halted,
    output logic               illegal,
    output logic               bus_err,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_HALT   = 7'b0000000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_ALU  = 4'd2,
        S_WB_ALU    = 4'd3,
        S_MEM_ADDR  = 4'd4,
        S_MEM_LOAD  = 4'd5,
        S_WB_LOAD   = 4'd6,
        S_MEM_STORE = 4'd7,
        S_BRANCH    = 4'd8,
        S_HALT      = 4'd9
    } state_t;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              is_imm;
    logic              is_store;
    logic              in_wait;
    logic              expired;

    // Instruction class is captured once in DECODE so later states never look at opcode.
    assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_LOAD) || (state_q == S_MEM_STORE);
    assign expired = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign state   = reset ? state_q : 4'd0;

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            wait_cnt    <= '0;
            instr_count <= '0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            bus_err     <= 1'b0;
            is_imm      <= 1'b0;
            is_store    <= 1'b0;
        end else begin
            wait_cnt <= '0;
            if (pc_write)
                instr_count <= instr_count + COUNT_W'(1);

            if (in_wait && !mem_ready) begin
                if (expired) begin
                    state_q <= S_HALT;
                    halted  <= 1'b1;
                    bus_err <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end else begin
                case (state_q)
                    S_FETCH:  state_q <= S_DECODE;
                    S_DECODE: begin
                        is_imm   <= (opcode == OP_I);
                        is_store <= (opcode == OP_STORE);
                        case (opcode)
                            OP_R, OP_I:        state_q <= S_EXEC_ALU;
                            OP_LOAD, OP_STORE: state_q <= S_MEM_ADDR;
                            OP_BRANCH:         state_q <= S_BRANCH;
                            OP_HALT: begin
                                state_q <= S_HALT;
                                halted  <= 1'b1;
                            end
                            default: begin
                                state_q <= S_HALT;
                                halted  <= 1'b1;
                                illegal <= 1'b1;
                            end
                        endcase
                    end
                    S_EXEC_ALU:  state_q <= S_WB_ALU;
                    S_WB_ALU:    state_q <= S_FETCH;
                    S_MEM_ADDR:  state_q <= is_store ? S_MEM_STORE : S_MEM_LOAD;
                    S_MEM_LOAD:  state_q <= S_WB_LOAD;
                    S_WB_LOAD:   state_q <= S_FETCH;
                    S_MEM_STORE: state_q <= S_FETCH;
                    S_BRANCH:    state_q <= S_FETCH;
                    default:     state_q <= S_HALT;
                endcase
            end
        end
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        imem_read  = 1'b0;
        ir_write   = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 3'b000;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_read = 1'b1;
                ir_write  = mem_ready;
            end
            S_EXEC_ALU: begin
                alu_op  = is_imm ? 3'b011 : 3'b010;
                alu_src = is_imm;
            end
            S_WB_ALU: begin
                alu_op    = is_imm ? 3'b011 : 3'b010;
                alu_src   = is_imm;
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            S_MEM_ADDR: alu_src = 1'b1;
            S_MEM_LOAD: begin
                dmem_read = 1'b1;
                alu_src   = 1'b1;
            end
            S_WB_LOAD: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                alu_src    = 1'b1;
            end
            S_MEM_STORE: begin
                dmem_write = 1'b1;
                alu_src    = 1'b1;
                pc_write   = mem_ready;
            end
            S_BRANCH: begin
                alu_op   = 3'b001;
                pc_write = 1'b1;
                pc_src   = zero;
            end
            default: ;
        endcase

        // Holding reset low silences the datapath immediately, even mid-instruction.
        if (!reset) begin
            imem_read  = 1'b0;
            ir_write   = 1'b0;
            dmem_read  = 1'b0;
            dmem_write = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            alu_src    = 1'b0;
            alu_op     = 3'b000;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
// Self-checking bench for multicycle_control: opcode decode table, directed corner sequences
// and randomized instruction streams checked against a per-instruction cycle-trace model.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;

    logic        imem_read, ir_write, dmem_read, dmem_write, pc_write, pc_src, alu_src;
    logic [2:0]  alu_op;
    logic        mem_to_reg, reg_write, halted, illegal, bus_err;
    logic [3:0]  state;
    logic [31:0] instr_count;

    logic        d2_imem_read, d2_ir_write, d2_dmem_read, d2_dmem_write, d2_pc_write;
    logic        d2_pc_src, d2_alu_src;
    logic [2:0]  d2_alu_op;
    logic        d2_mem_to_reg, d2_reg_write, d2_halted, d2_illegal, d2_bus_err;
    logic [3:0]  d2_state;
    logic [2:0]  d2_instr_count;

    multicycle_control #(.MEM_TIMEOUT(15), .COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .imem_read(imem_read), .ir_write(ir_write), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src),
        .alu_op(alu_op), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .halted(halted),
        .illegal(illegal), .bus_err(bus_err), .state(state), .instr_count(instr_count)
    );

    // Second instance: timeout disabled and a 3-bit counter to exercise wrap-around.
    multicycle_control #(.MEM_TIMEOUT(0), .COUNT_W(3)) dut2 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .imem_read(d2_imem_read), .ir_write(d2_ir_write), .dmem_read(d2_dmem_read),
        .dmem_write(d2_dmem_write), .pc_write(d2_pc_write), .pc_src(d2_pc_src),
        .alu_src(d2_alu_src), .alu_op(d2_alu_op), .mem_to_reg(d2_mem_to_reg),
        .reg_write(d2_reg_write), .halted(d2_halted), .illegal(d2_illegal),
        .bus_err(d2_bus_err), .state(d2_state), .instr_count(d2_instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [11:0] outs_act;
    assign outs_act = {imem_read, ir_write, dmem_read, dmem_write, pc_write, pc_src,
                       alu_src, alu_op, mem_to_reg, reg_write};

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] o(input logic imem, input logic irw, input logic dr,
                                      input logic dw, input logic pcw, input logic pcs,
                                      input logic as, input logic [2:0] aop,
                                      input logic m2r, input logic rw);
        return {imem, irw, dr, dw, pcw, pcs, as, aop, m2r, rw};
    endfunction

    // One expected clock cycle: the inputs to apply and the outputs the sequencer must show.
    typedef struct packed {
        logic        mr;
        logic        z;
        logic [6:0]  op;
        logic [3:0]  st;
        logic [11:0] outs;
        logic        ret;
    } cyc_t;

    cyc_t trace[$];

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    task automatic push(input logic mr, input logic z, input logic [6:0] op,
                        input logic [3:0] st, input logic [11:0] outs, input logic ret);
        cyc_t c;
        c.mr = mr; c.z = z; c.op = op; c.st = st; c.outs = outs; c.ret = ret;
        trace.push_back(c);
    endtask

    // Expand one instruction (0 R, 1 I, 2 load, 3 store, 4 branch) into its expected cycles.
    task automatic build(input int kind, input int wf, input int wm, input logic z);
        logic [6:0] op;
        logic [2:0] aop;
        logic       as;
        case (kind)
            0:       op = 7'b0110011;
            1:       op = 7'b0010011;
            2:       op = 7'b0000011;
            3:       op = 7'b0100011;
            default: op = 7'b1100011;
        endcase
        for (int i = 0; i < wf; i++)
            push(1'b0, rb(), rop(), 4'd0, o(1,0,0,0,0,0,0,3'b000,0,0), 1'b0);
        push(1'b1, rb(), rop(), 4'd0, o(1,1,0,0,0,0,0,3'b000,0,0), 1'b0);
        push(rb(), rb(), op, 4'd1, o(0,0,0,0,0,0,0,3'b000,0,0), 1'b0);
        case (kind)
            0, 1: begin
                aop = (kind == 0) ? 3'b010 : 3'b011;
                as  = (kind == 1);
                push(rb(), rb(), op, 4'd2, o(0,0,0,0,0,0,as,aop,0,0), 1'b0);
                push(rb(), rb(), op, 4'd3, o(0,0,0,0,1,0,as,aop,0,1), 1'b1);
            end
            2: begin
                push(rb(), rb(), op, 4'd4, o(0,0,0,0,0,0,1,3'b000,0,0), 1'b0);
                for (int i = 0; i < wm; i++)
                    push(1'b0, rb(), op, 4'd5, o(0,0,1,0,0,0,1,3'b000,0,0), 1'b0);
                push(1'b1, rb(), op, 4'd5, o(0,0,1,0,0,0,1,3'b000,0,0), 1'b0);
                push(rb(), rb(), op, 4'd6, o(0,0,0,0,1,0,1,3'b000,1,1), 1'b1);
            end
            3: begin
                push(rb(), rb(), op, 4'd4, o(0,0,0,0,0,0,1,3'b000,0,0), 1'b0);
                for (int i = 0; i < wm; i++)
                    push(1'b0, rb(), op, 4'd7, o(0,0,0,1,0,0,1,3'b000,0,0), 1'b0);
                push(1'b1, rb(), op, 4'd7, o(0,0,0,1,1,0,1,3'b000,0,0), 1'b1);
            end
            default: push(rb(), z, op, 4'd8, o(0,0,0,0,1,z,0,3'b001,0,0), 1'b1);
        endcase
    endtask

    // Apply up to n queued cycles (all when n < 0); a retiring cycle bumps the count after its edge.
    task automatic run_trace(input string tag, input int n);
        cyc_t c;
        int   done;
        done = 0;
        while (trace.size() > 0 && (n < 0 || done < n)) begin
            c = trace.pop_front();
            mem_ready = c.mr;
            zero      = c.z;
            opcode    = c.op;
            #2;
            check($sformatf("%s cyc%0d st%0d outs", tag, done, c.st),
                  {state, outs_act, halted, illegal, bus_err}, {c.st, c.outs, 3'b000});
            check($sformatf("%s cyc%0d instr_count", tag, done), instr_count, exp_count);
            @(posedge clk);
            #1;
            if (c.ret) exp_count++;
            done++;
        end
        trace.delete();
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        exp_count = '0;
        #1;
        check("reset_clears", {state, halted, illegal, bus_err, instr_count}, 64'd0);
    endtask

    typedef struct {
        logic [6:0] op;
        logic [3:0] st;
        logic       h;
        logic       il;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int wf, wm;

        vecs[0] = '{7'b0110011, 4'd2, 1'b0, 1'b0};
        vecs[1] = '{7'b0010011, 4'd2, 1'b0, 1'b0};
        vecs[2] = '{7'b0000011, 4'd4, 1'b0, 1'b0};
        vecs[3] = '{7'b0100011, 4'd4, 1'b0, 1'b0};
        vecs[4] = '{7'b1100011, 4'd8, 1'b0, 1'b0};
        vecs[5] = '{7'b0000000, 4'd9, 1'b1, 1'b0};
        vecs[6] = '{7'b1111111, 4'd9, 1'b1, 1'b1};
        vecs[7] = '{7'b0010111, 4'd9, 1'b1, 1'b1};
        vecs[8] = '{7'b1101111, 4'd9, 1'b1, 1'b1};

        reset     = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = 7'd0;
        exp_count = '0;
        @(posedge clk);
        #1;

        // Reset held low: strobes forced off even though FETCH would otherwise request.
        mem_ready = 1'b1;
        zero      = 1'b1;
        #2;
        check("reset_forced", {state, outs_act}, 64'd0);
        reset     = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("post_reset", {state, outs_act, halted, illegal, bus_err, instr_count},
              {4'd0, o(1,0,0,0,0,0,0,3'b000,0,0), 3'b000, 32'd0});

        // Directed instruction sequences, including the last allowed wait cycle.
        build(0, 0, 0, 1'b0);
        build(2, 0, 2, 1'b0);
        build(4, 0, 0, 1'b1);
        build(4, 0, 0, 1'b0);
        build(3, 1, 0, 1'b0);
        build(1, 0, 0, 1'b0);
        build(3, 0, 3, 1'b0);
        build(2, 0, 14, 1'b0);
        build(0, 14, 0, 1'b0);
        build(3, 2, 14, 1'b0);
        run_trace("directed", -1);

        // Random instruction stream.
        for (int n = 0; n < 60; n++) begin
            wf = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
            wm = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
            build(int'($urandom_range(0, 4)), wf, wm, rb());
            run_trace($sformatf("rand%0d", n), -1);
        end

        // Reset arriving while a store waits on memory.
        build(3, 0, 3, 1'b0);
        run_trace("store_pre_reset", 4);
        reset     = 1'b0;
        mem_ready = 1'b0;
        #2;
        check("reset_in_store outs", {state, outs_act}, 64'd0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        exp_count = '0;
        #1;
        check("reset_in_store after", {state, instr_count, halted, illegal, bus_err}, 64'd0);

        // Opcode decode table.
        foreach (vecs[i]) begin
            do_reset();
            mem_ready = 1'b1;
            opcode    = vecs[i].op;
            @(posedge clk);
            #1;
            mem_ready = rb();
            #1;
            check($sformatf("decode%0d in_decode", i), state, 4'd1);
            @(posedge clk);
            #1;
            check($sformatf("decode%0d result", i), {state, halted, illegal, bus_err},
                  {vecs[i].st, vecs[i].h, vecs[i].il, 1'b0});
        end

        // Illegal opcode after one retired instruction: HALT absorbs, nothing strobes.
        do_reset();
        build(0, 0, 0, 1'b0);
        run_trace("pre_illegal", -1);
        mem_ready = 1'b1;
        opcode    = rop();
        @(posedge clk);
        #1;
        opcode = 7'h7f;
        #1;
        check("illegal in_decode", state, 4'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            mem_ready = rb();
            zero      = rb();
            opcode    = rop();
            #1;
            check($sformatf("illegal_halt%0d", i),
                  {state, outs_act, halted, illegal, bus_err, instr_count},
                  {4'd9, 12'd0, 3'b110, 32'd1});
            @(posedge clk);
            #1;
        end

        // Fetch timeout: exactly 15 not-ready cycles, then HALT with bus_err.
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            check($sformatf("fetch_wait%0d", i), {state, imem_read, bus_err}, {4'd0, 1'b1, 1'b0});
            @(posedge clk);
            #1;
        end
        #1;
        check("fetch_timeout", {state, outs_act, halted, illegal, bus_err},
              {4'd9, 12'd0, 3'b101});

        // Load-wait timeout.
        do_reset();
        build(2, 0, 15, 1'b0);
        run_trace("load_timeout", 18);
        #1;
        check("load_timeout end", {state, outs_act, halted, illegal, bus_err, instr_count},
              {4'd9, 12'd0, 3'b101, 32'd0});

        // Counter wrap on the narrow instance; its timeout is disabled.
        do_reset();
        for (int i = 0; i < 9; i++) build(0, 0, 0, 1'b0);
        run_trace("wrap", -1);
        check("wrap d2_count", d2_instr_count, 3'd1);
        mem_ready = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("no_timeout d2", {d2_state, d2_imem_read, d2_bus_err, d2_halted},
              {4'd0, 1'b1, 1'b0, 1'b0});
        check("timeout dut", {state, bus_err}, {4'd9, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
